// File: rtl/uart_pkg.sv
// Shared definitions for the 4x-oversampled UART link stage: bit timing
// constants and the state encoding used by both the RX and TX state machines.
package uart_pkg;

    localparam int OVERSAMPLE = 4;
    localparam int HALF_BIT   = 2;

    // The phase counter runs 0..OVERSAMPLE-1 across one bit time.
    localparam logic [1:0] PHASE_LAST   = 2'(OVERSAMPLE - 1);
    // Start bit is checked HALF_BIT cycles after the falling edge is seen.
    localparam logic [1:0] START_SAMPLE = 2'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_x4_rx.sv
// UART receiver: input synchronizer plus a 4x-oversampled 8N1 deframer that
// samples each bit in the middle of its four-cycle window.
module uart_x4_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 UART_CLK_X4,
    input  logic                 UART_RST_N,
    input  logic                 UART_RX,
    output logic                 received,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 is_receiving,
    output logic                 recv_error
);

    localparam int BIT_W = $clog2(DATA_BITS + 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    uart_state_e            rx_state;
    logic [1:0]             rx_phase;
    logic [BIT_W-1:0]       rx_bit_idx;
    logic [DATA_BITS-1:0]   rx_shift;

    // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge UART_CLK_X4 or negedge UART_RST_N) begin
        if (!UART_RST_N) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge UART_CLK_X4 or negedge UART_RST_N) begin
        if (!UART_RST_N) begin
            rx_state     <= ST_IDLE;
            rx_phase     <= '0;
            rx_bit_idx   <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            received     <= 1'b0;
            recv_error   <= 1'b0;
            is_receiving <= 1'b0;
        end else begin
            received   <= 1'b0;
            recv_error <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        rx_state     <= ST_START;
                        rx_phase     <= '0;
                        is_receiving <= 1'b1;
                    end
                end
                ST_START: begin
                    if (rx_phase == START_SAMPLE) begin
                        rx_phase <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-start-bit: treat as noise.
                            rx_state     <= ST_IDLE;
                            is_receiving <= 1'b0;
                        end else begin
                            rx_state   <= ST_DATA;
                            rx_bit_idx <= '0;
                        end
                    end else begin
                        rx_phase <= rx_phase + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_phase == PHASE_LAST) begin
                        rx_phase <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_idx == LAST_BIT) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 1'b1;
                        end
                    end else begin
                        rx_phase <= rx_phase + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_phase == PHASE_LAST) begin
                        rx_phase <= '0;
                        if (rx_s) begin
                            rx_byte      <= rx_shift;
                            received     <= 1'b1;
                            is_receiving <= 1'b0;
                            rx_state     <= ST_IDLE;
                        end else begin
                            recv_error <= 1'b1;
                            rx_state   <= ST_RECOVER;
                        end
                    end else begin
                        rx_phase <= rx_phase + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    // Wait out a break so a held-low line cannot start a bogus frame.
                    if (rx_s) begin
                        rx_state     <= ST_IDLE;
                        is_receiving <= 1'b0;
                    end
                end
                default: begin
                    rx_state     <= ST_IDLE;
                    is_receiving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_x4_phy.sv
// Full-duplex 8N1 UART PHY at 4x baud: instantiates the receiver and holds the
// transmit state machine and shift register inline.
module uart_x4_phy
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 UART_CLK_X4,
    input  logic                 UART_RST_N,
    input  logic                 UART_RX,
    output logic                 UART_TX,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 is_transmitting,
    output logic                 received,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 is_receiving,
    output logic                 recv_error
);

    localparam int BIT_W = $clog2(DATA_BITS + 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_e          tx_state;
    logic [1:0]           tx_phase;
    logic [BIT_W-1:0]     tx_bit_idx;
    logic [DATA_BITS-1:0] tx_shift;

    uart_x4_rx #(
        .DATA_BITS   (DATA_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .UART_CLK_X4  (UART_CLK_X4),
        .UART_RST_N   (UART_RST_N),
        .UART_RX      (UART_RX),
        .received     (received),
        .rx_byte      (rx_byte),
        .is_receiving (is_receiving),
        .recv_error   (recv_error)
    );

    // Handshake: transmit is a one-cycle request, taken on a rising edge only when
    // is_transmitting is low; tx_byte is captured on that edge and ignored afterwards.
    always_ff @(posedge UART_CLK_X4 or negedge UART_RST_N) begin
        if (!UART_RST_N) begin
            tx_state        <= ST_IDLE;
            tx_phase        <= '0;
            tx_bit_idx      <= '0;
            tx_shift        <= '0;
            UART_TX         <= 1'b1;
            is_transmitting <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (transmit && !is_transmitting) begin
                        tx_shift        <= tx_byte;
                        UART_TX         <= 1'b0;
                        is_transmitting <= 1'b1;
                        tx_phase        <= '0;
                        tx_state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_phase == PHASE_LAST) begin
                        tx_phase   <= '0;
                        tx_bit_idx <= '0;
                        UART_TX    <= tx_shift[0];
                        tx_shift   <= {1'b0, tx_shift[DATA_BITS-1:1]};
                        tx_state   <= ST_DATA;
                    end else begin
                        tx_phase <= tx_phase + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_phase == PHASE_LAST) begin
                        tx_phase <= '0;
                        if (tx_bit_idx == LAST_BIT) begin
                            UART_TX  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            UART_TX    <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[DATA_BITS-1:1]};
                            tx_bit_idx <= tx_bit_idx + 1'b1;
                        end
                    end else begin
                        tx_phase <= tx_phase + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_phase == PHASE_LAST) begin
                        tx_phase        <= '0;
                        is_transmitting <= 1'b0;
                        tx_state        <= ST_IDLE;
                    end else begin
                        tx_phase <= tx_phase + 1'b1;
                    end
                end
                default: begin
                    UART_TX         <= 1'b1;
                    is_transmitting <= 1'b0;
                    tx_state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_x4_phy.sv
// Bench for uart_x4_phy: drives framed serial data and transmit requests and
// compares against a bit-time model of 8N1 framing at 4 cycles per bit.
module tb_uart_x4_phy;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx_line;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       is_transmitting;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       recv_error;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    // Scoreboard: expected good bytes with the cycle their strobe is due,
    // and expected framing-error strobe cycles.
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         err_cyc_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_x4_phy dut (
        .UART_CLK_X4     (clk),
        .UART_RST_N      (rst_n),
        .UART_RX         (rx_line),
        .UART_TX         (tx_line),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_receiving    (is_receiving),
        .recv_error      (recv_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (received) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                last_good = exp_q.pop_front();
                check("rx_byte", rx_byte, last_good);
                check("rx_strobe_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        if (recv_error) begin
            if (err_cyc_q.size() == 0) begin
                check("rx_unexpected_error", 32'd1, 32'd0);
            end else begin
                check("rx_error_cycle", cyc, err_cyc_q.pop_front());
                check("rx_byte_held_on_error", rx_byte, last_good);
            end
        end
        if (received || recv_error) begin
            check("strobe_exclusive", received && recv_error, 32'd0);
            check("strobe_not_repeated", prev_strobe, 32'd0);
        end
        prev_strobe = received || recv_error;
    end

    // ---------------- driver tasks ----------------
    // Drives one frame on the RX line starting at the next negedge (cycle c);
    // the synchronized line goes low at S = c+2, so the strobe is due at c+41.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        int         c;
        fr = {stop_bit, b, 1'b0};
        c  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                c = cyc;
                if (stop_bit) begin
                    exp_q.push_back(b);
                    exp_cyc_q.push_back(c + 41);
                end else begin
                    err_cyc_q.push_back(c + 41);
                end
            end
            if (i == 2) check("rx_busy_at_s", is_receiving, 32'd0);
            if (i == 3) check("rx_busy_at_s1", is_receiving, 32'd1);
            rx_drv = fr[i/4];
        end
    endtask

    // Raises transmit for one cycle; t is the accept edge cycle T.
    task automatic tx_go(input logic [7:0] b, output int t);
        @(negedge clk);
        transmit = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        transmit = 1'b0;
        t = cyc;
    endtask

    // Called at the negedge of cycle T; checks the whole TX frame and pokes an
    // ignored request mid-frame plus random tx_byte churn.
    task automatic tx_check_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            check("tx_line", tx_line, fr[n/4]);
            check("tx_busy", is_transmitting, 32'd1);
            transmit = (n == 20);
            tx_byte  = 8'($urandom);
        end
        transmit = 1'b0;
        @(negedge clk);
        check("tx_idle_line", tx_line, 32'd1);
        check("tx_done", is_transmitting, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         t1;
        int         t2;
        int         t3;
        logic [7:0] b;

        // 1: reset held with RX low and transmit high
        rx_drv   = 1'b0;
        transmit = 1'b1;
        tx_byte  = 8'hFF;
        #2 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_tx_line", tx_line, 32'd1);
            check("rst_tx_busy", is_transmitting, 32'd0);
            check("rst_received", received, 32'd0);
            check("rst_rx_byte", rx_byte, 32'd0);
            check("rst_rx_busy", is_receiving, 32'd0);
            check("rst_recv_error", recv_error, 32'd0);
        end
        rx_drv   = 1'b1;
        transmit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle_rx", is_receiving, 32'd0);

        // 2: TX 0xA5, ignored mid-frame request, back-to-back second frame
        tx_go(8'hA5, t1);
        tx_check_frame(8'hA5);
        b = 8'($urandom);
        transmit = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        transmit = 1'b0;
        check("tx_b2b_accept_cycle", cyc, t1 + 41);
        tx_check_frame(b);
        repeat (5) @(negedge clk);

        // 3: RX 0x3C at phase offsets 0..3, then random bytes
        for (int off = 0; off < 4; off++) begin
            repeat (off + 3) @(negedge clk);
            send_rx(8'h3C, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(2, 6)) @(negedge clk);
            send_rx(8'($urandom_range(0, 255)), 1'b1);
        end
        repeat (6) @(negedge clk);

        // 4: one-cycle glitch, then 0x81
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy", is_receiving, 32'd1);
        repeat (2) @(negedge clk);
        check("glitch_back_idle", is_receiving, 32'd0);
        repeat (4) @(negedge clk);
        send_rx(8'h81, 1'b1);
        repeat (6) @(negedge clk);
        check("rx_after_glitch", rx_byte, 32'h81);

        // 5: framing error with a held-low line, then 0xF0
        send_rx(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("break_still_busy", is_receiving, 32'd1);
        check("break_rx_byte_held", rx_byte, 32'h81);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        check("break_released", is_receiving, 32'd0);
        send_rx(8'hF0, 1'b1);
        repeat (6) @(negedge clk);

        // 6: loopback 0x00, 0xFF, 0x6C back-to-back
        loop_en = 1'b1;
        repeat (3) @(negedge clk);
        tx_go(8'h00, t1);
        exp_q.push_back(8'h00);
        exp_cyc_q.push_back(t1 + 41);
        repeat (39) @(negedge clk);
        tx_go(8'hFF, t2);
        exp_q.push_back(8'hFF);
        exp_cyc_q.push_back(t2 + 41);
        check("loop_b2b_2", t2, t1 + 41);
        repeat (39) @(negedge clk);
        tx_go(8'h6C, t3);
        exp_q.push_back(8'h6C);
        exp_cyc_q.push_back(t3 + 41);
        check("loop_b2b_3", t3, t2 + 41);
        repeat (48) @(negedge clk);
        check("loop_last_byte", rx_byte, 32'h6C);

        // loopback with reset in the middle of the second frame
        b = 8'($urandom);
        tx_go(b, t1);
        exp_q.push_back(b);
        exp_cyc_q.push_back(t1 + 41);
        repeat (39) @(negedge clk);
        tx_go(8'h00, t2);
        repeat (15) @(negedge clk);
        check("pre_rst_tx_low", tx_line, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_line", tx_line, 32'd1);
        check("mid_rst_tx_busy", is_transmitting, 32'd0);
        check("mid_rst_rx_busy", is_receiving, 32'd0);
        check("mid_rst_rx_byte", rx_byte, 32'd0);
        last_good = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_tx_line", tx_line, 32'd1);

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("err_q_drained", err_cyc_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
